// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, one input bit per clock.
// Ports: clock/reset (async, active-high); start, bin_i in; busy, done,
//   overflow, thousands_o/hundreds_o/tens_o/ones_o (registered BCD) out.
// Optional macro BCD_SATURATE_EN: overflowed results display as 9999.
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       thousands_o,
    output logic [3:0]       hundreds_o,
    output logic [3:0]       tens_o,
    output logic [3:0]       ones_o
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [19:0]      acc;
    logic [BIN_W-1:0] bin_sr;
    logic [CNT_W-1:0] cnt;

    logic [19:0]      adj;
    logic [19:0]      acc_nxt;
    logic [BIN_W-1:0] bin_nxt;
    logic             ovf_nxt;
    logic             unused_msb;

    // Add-3 correction on every digit that would exceed 9 after doubling.
    always_comb begin
        adj = acc;
        for (int d = 0; d < 5; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // Ten-thousands digit never reaches 8 for BIN_W <= 16, so its MSB
    // is always zero before the shift and can be dropped.
    assign unused_msb = adj[19];
    assign acc_nxt    = {adj[18:0], bin_sr[BIN_W-1]};
    assign bin_nxt    = {bin_sr[BIN_W-2:0], 1'b0};
    assign ovf_nxt    = (acc_nxt[19:16] != 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            bin_sr      <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            thousands_o <= 4'd0;
            hundreds_o  <= 4'd0;
            tens_o      <= 4'd0;
            ones_o      <= 4'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        bin_sr <= bin_i;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc    <= acc_nxt;
                    bin_sr <= bin_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= ovf_nxt;
                        state    <= IDLE;
`ifdef BCD_SATURATE_EN
                        if (ovf_nxt) begin
                            thousands_o <= 4'd9;
                            hundreds_o  <= 4'd9;
                            tens_o      <= 4'd9;
                            ones_o      <= 4'd9;
                        end else begin
                            thousands_o <= acc_nxt[15:12];
                            hundreds_o  <= acc_nxt[11:8];
                            tens_o      <= acc_nxt[7:4];
                            ones_o      <= acc_nxt[3:0];
                        end
`else
                        thousands_o <= acc_nxt[15:12];
                        hundreds_o  <= acc_nxt[11:8];
                        tens_o      <= acc_nxt[7:4];
                        ones_o      <= acc_nxt[3:0];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
